instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Reverse of the instruction decoder: takes a 6-bit alu_control operation code plus register/immediate fields and assembles the 32-bit instruction word that the decoder maps back to the same alu_control. Instruction words are buffered in an output FIFO behind valid/ready handshakes on both sides. Used by the instruction-stream generator and self-test loader that feed program memory and the decode path.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2
CNT_WIDTH, 8, width of the saturating illegal-code counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  encode request valid
in_ready  output  1  encoder can accept a request this cycle
in_alu_control  input  6  operation code, same encoding the decoder produces
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2 (R-type only)
in_imm  input  12  immediate (I-type only; [4:0] = shamt for shifts)
out_valid  output  1  FIFO head holds a word
out_ready  input  1  consumer accepts head word
out_instr  output  32  FIFO head instruction word
err_illegal  output  1  one-cycle pulse: an illegal code was accepted
illegal_count  output  CNT_WIDTH  saturating count of illegal codes accepted
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Word layout: [31:25] funct7/imm[11:5], [24:20] rs2/imm[4:0], [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode.
- R-type (opcode 0110011, funct7 0000000): codes 000000..000111 map to funct3 000..111 (ADD,SLT,SLTU,AND,OR,XOR,SLL,SRL).
- R-type, funct7 0100000: 001000 SUB uses funct3 010; 001001 SRA uses funct3 011.
- I-type1 (opcode 1001100): codes 111111,111110,...,111000 map to funct3 000,001,...,111; imm occupies [31:20].
- For SLLI (111001) and SRLI (111000), [31:25] is forced to 0000000 and [24:20] = in_imm[4:0].
- I-type2 (opcode 1001101): 101010 SRAI, funct3 111, [31:25] = 0100000, [24:20] = in_imm[4:0].
- All other codes are illegal.
- Unused fields are zero: rs2 is ignored for I-type and imm is ignored for R-type.
- Request handshake: a request is accepted when in_valid && in_ready, with in_ready = (fifo_level != FIFO_DEPTH). No full-bypass: when full, in_ready stays 0 even if the head pops in the same cycle.
- Latency: a legal word accepted in cycle N is written to the FIFO at edge N and is visible at the head (out_valid=1) in cycle N+1 when the FIFO was empty.
- Output handshake: pop when out_valid && out_ready. out_instr is stable while out_valid && !out_ready. Order is strictly FIFO.
- Simultaneous push and pop: both happen and fifo_level is unchanged. A push into an empty FIFO while a pop is requested is legal; the pop has no effect because out_valid is 0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Illegal code accepted: no FIFO write. err_illegal = 1 in the next cycle only. illegal_count increments and saturates at all-ones.
- Reset asserted (including mid-stream):
  - FIFO emptied; fifo_level = 0, out_valid = 0, out_instr = 0.
  - err_illegal = 0, illegal_count = 0.
  - in_ready = 1 on the first cycle after reset deasserts.

Optional Feature:
ENC_NOP_ON_ILLEGAL_EN
- Defined: an illegal code still pulses err_illegal and counts, and also writes the NOP word 32'h0000004C (ADDI x0,x0,0) into the FIFO, so stream length is preserved.
- Undefined: illegal codes are dropped as described in Behaviour.

Test Plan:
- Reset, then code 000000 with rd=3, rs1=1, rs2=2 -> out_instr=32'h002081B3, out_valid rises the cycle after accept, fifo_level=1.
- Code 001000 with rd=5, rs1=6, rs2=7 -> 32'h407322B3; code 111111 with rd=1, rs1=0, imm=12'h7FF -> 32'h7FF000CC.
- Code 101010 with rd=2, rs1=2, imm=12'hFE3 -> 32'h4031714D (upper imm bits overridden, shamt=3).
- out_ready=0 with 5 back-to-back requests, FIFO_DEPTH=4 -> in_ready=0 after the 4th accept, fifo_level=4; then out_ready=1 -> 4 words drain in order; simultaneous push/pop keeps the level constant.
- Code 6'b010000 -> err_illegal pulses one cycle, illegal_count=1, no write (with ENC_NOP_ON_ILLEGAL_EN: 32'h0000004C written). 300 illegal codes -> illegal_count=8'hFF.
- Reset asserted with 3 words queued -> immediately out_valid=0, fifo_level=0, illegal_count=0; after release the next request encodes correctly.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: encode requests flow in, instruction words flow out.
// slave is the encoder's view; master is the view of whoever drives requests and drains words.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_alu_control;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_alu_control, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, in_alu_control, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles 32-bit instruction words from alu_control codes and buffers them in an output FIFO.
// Optional macro ENC_NOP_ON_ILLEGAL_EN: illegal codes also enqueue a NOP so stream length is kept.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    instr_encoder_if.slave                bus,
    output logic                          err_illegal,
    output logic [CNT_WIDTH-1:0]          illegal_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I1 = 7'b1001100;
    localparam logic [6:0] OP_I2 = 7'b1001101;

    // Result is {legal, word}; word is zero for illegal codes.
    function automatic logic [32:0] encode(
        input logic [5:0]  code,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [32:0] r;
        r = '0;
        case (code)
            6'b000000, 6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111:
                r = {1'b1, 7'b0000000, rs2, rs1, code[2:0], rd, OP_R};
            6'b001000: r = {1'b1, 7'b0100000, rs2, rs1, 3'b010, rd, OP_R};
            6'b001001: r = {1'b1, 7'b0100000, rs2, rs1, 3'b011, rd, OP_R};
            // Logical shifts keep only the shamt; upper immediate bits are forced clear.
            6'b111000, 6'b111001:
                r = {1'b1, 7'b0000000, imm[4:0], rs1, ~code[2:0], rd, OP_I1};
            6'b111010, 6'b111011, 6'b111100, 6'b111101, 6'b111110, 6'b111111:
                r = {1'b1, imm, rs1, ~code[2:0], rd, OP_I1};
            6'b101010: r = {1'b1, 7'b0100000, imm[4:0], rs1, 3'b111, rd, OP_I2};
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + CNT_WIDTH'(1);
    endfunction

    logic [31:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 err_p1;
    logic [CNT_WIDTH-1:0] cnt;

    logic [32:0] enc;
    logic        legal;
    logic [31:0] wdata;
    logic        accept;
    logic        push;
    logic        pop;

    assign enc   = encode(bus.in_alu_control, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    assign legal = enc[32];

    // No full-bypass: a pop in the same cycle does not open a slot for a push.
    assign bus.in_ready = (level != LVL_W'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ENC_NOP_ON_ILLEGAL_EN
    localparam logic [31:0] NOP_WORD = 32'h0000004C;
    assign push  = accept;
    assign wdata = legal ? enc[31:0] : NOP_WORD;
`else
    assign push  = accept && legal;
    assign wdata = enc[31:0];
`endif

    assign bus.out_valid = (level != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : '0;

    assign err_illegal   = err_p1;
    assign illegal_count = cnt;
    assign fifo_level    = level;

    // Stage p0 -> p1: FIFO control, error pulse and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err_p1 <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                level <= level + LVL_W'(1);
            else if (!push && pop)
                level <= level - LVL_W'(1);
            err_p1 <= accept && !legal;
            if (accept && !legal)
                cnt <= sat_inc(cnt);
        end
    end

    // Storage carries no reset; out_instr is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors with a queue-based reference model checked every cycle.
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       err_illegal;
    logic [7:0] illegal_count;
    logic [2:0] fifo_level;

    instr_encoder_if bus();

    instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .err_illegal   (err_illegal),
        .illegal_count (illegal_count),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          mdl_acc;
    bit          mdl_pop;
    logic [32:0] mdl_e;

    // Field-by-field assembly from the instruction-format rules; returns {legal, word}.
    function automatic logic [32:0] model_enc(input int code, input int rd, input int rs1,
                                              input int rs2, input int imm);
        longint f7, f2, f3, op, w;
        bit ok;
        ok = 1'b1; f7 = 0; f2 = 0; f3 = 0; op = 0;
        if (code < 8) begin
            op = 51; f3 = code; f2 = rs2;
        end else if (code == 8 || code == 9) begin
            op = 51; f7 = 32; f3 = code - 6; f2 = rs2;
        end else if (code >= 56) begin
            op = 76; f3 = 63 - code; f2 = imm % 32;
            f7 = (code >= 58) ? imm / 32 : 0;
        end else if (code == 42) begin
            op = 77; f3 = 7; f7 = 32; f2 = imm % 32;
        end else begin
            ok = 1'b0;
        end
        w = ok ? ((f7 << 25) + (f2 << 20) + (longint'(rs1) << 15) + (f3 << 12)
                  + (longint'(rd) << 7) + op) : 0;
        return {ok, w[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on the same edges as the design.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            mdl_acc = bus.in_valid && (q.size() != DEPTH);
            mdl_pop = (q.size() != 0) && bus.out_ready;
            mdl_e   = model_enc(int'(bus.in_alu_control), int'(bus.in_rd), int'(bus.in_rs1),
                                int'(bus.in_rs2), int'(bus.in_imm));
            if (mdl_pop)
                void'(q.pop_front());
            m_err = mdl_acc && !mdl_e[32];
            if (mdl_acc) begin
                if (mdl_e[32]) begin
                    q.push_back(mdl_e[31:0]);
                end else begin
                    if (m_cnt < 255)
                        m_cnt++;
`ifdef ENC_NOP_ON_ILLEGAL_EN
                    q.push_back(32'h0000004C);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fifo_level",    32'(fifo_level),        32'(q.size()));
        chk("out_valid",     32'(bus.out_valid),     32'(q.size() != 0));
        chk("out_instr",     bus.out_instr,          (q.size() != 0) ? q[0] : 32'h0);
        chk("in_ready",      32'(bus.in_ready),      32'(q.size() != DEPTH));
        chk("err_illegal",   32'(err_illegal),       32'(m_err));
        chk("illegal_count", 32'(illegal_count),     32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm);
        bus.in_valid       = 1'b1;
        bus.in_alu_control = c;
        bus.in_rd          = rd;
        bus.in_rs1         = rs1;
        bus.in_rs2         = rs2;
        bus.in_imm         = imm;
    endtask

    task automatic single(input string name, input logic [5:0] c, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                          input logic [31:0] lit);
        req(c, rd, rs1, rs2, imm);
        step();
        bus.in_valid = 1'b0;
        chk(name, bus.out_instr, lit);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    logic [32:0] pin;
    logic [5:0]  ill [6] = '{6'b010000, 6'b001010, 6'b100000, 6'b110101, 6'b011111, 6'b101011};

    initial begin
        bus.in_valid = 1'b0; bus.in_alu_control = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;

        pin = model_enc(0, 3, 1, 2, 0);       chk("model_add",  pin[31:0], 32'h002081B3);
        pin = model_enc(8, 5, 6, 7, 0);       chk("model_sub",  pin[31:0], 32'h407322B3);
        pin = model_enc(63, 1, 0, 0, 'h7FF);  chk("model_addi", pin[31:0], 32'h7FF000CC);
        pin = model_enc(42, 2, 2, 0, 'hFE3);  chk("model_srai", pin[31:0], 32'h4031714D);
        pin = model_enc(16, 0, 0, 0, 0);      chk("model_illegal", 32'(pin[32]), 32'h0);

        step(); step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_level",     32'(fifo_level),    32'h0);
        chk("rst_count",     32'(illegal_count), 32'h0);
        chk("rst_out_instr", bus.out_instr,      32'h0);
        reset = 1'b1;
        step();
        chk("ready_after_reset", 32'(bus.in_ready), 32'h1);

        req(6'b000000, 5'd3, 5'd1, 5'd2, 12'hFFF);
        chk("add_not_yet_valid", 32'(bus.out_valid), 32'h0);
        step();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'h1);
        chk("add_word",  bus.out_instr,      32'h002081B3);
        chk("add_level", 32'(fifo_level),    32'h1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("add_drained", 32'(fifo_level), 32'h0);

        single("sub_word",  6'b001000, 5'd5, 5'd6, 5'd7,  12'h000, 32'h407322B3);
        single("addi_word", 6'b111111, 5'd1, 5'd0, 5'd31, 12'h7FF, 32'h7FF000CC);
        single("srai_word", 6'b101010, 5'd2, 5'd2, 5'd31, 12'hFE3, 32'h4031714D);

        // Five back-to-back requests against a held consumer.
        for (int i = 0; i < 5; i++) begin
            req(6'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'h0);
            step();
            if (i == 3) begin
                chk("full_ready", 32'(bus.in_ready), 32'h0);
                chk("full_level", 32'(fifo_level),   32'h4);
            end
        end
        chk("full_hold_level", 32'(fifo_level), 32'h4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_level", 32'(fifo_level), 32'h0);
        bus.out_ready = 1'b0;

        req(6'b001001, 5'd9, 5'd10, 5'd11, 12'h0); step();
        req(6'b000110, 5'd12, 5'd13, 5'd14, 12'h0); step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req(6'(56 + i), 5'(i), 5'(i + 4), 5'd0, 12'(i * 300 + 7));
            step();
            chk("pushpop_level", 32'(fifo_level), 32'h2);
        end
        bus.in_valid = 1'b0;
        step(); step();
        bus.out_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            req(6'(i + 4), 5'(i), 5'(i), 5'(i), 12'h0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("no_bypass_level", 32'(fifo_level), 32'h3);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b0;

        req(6'b010000, 5'd1, 5'd1, 5'd1, 12'h1);
        step();
        bus.in_valid = 1'b0;
        chk("illegal_pulse", 32'(err_illegal),   32'h1);
        chk("illegal_count", 32'(illegal_count), 32'h1);
`ifdef ENC_NOP_ON_ILLEGAL_EN
        chk("illegal_nop_level", 32'(fifo_level), 32'h1);
        chk("illegal_nop_word",  bus.out_instr,   32'h0000004C);
`else
        chk("illegal_no_write",  32'(fifo_level), 32'h0);
`endif
        step();
        chk("illegal_pulse_end", 32'(err_illegal), 32'h0);
        bus.out_ready = 1'b1;
        step();

        for (int c = 0; c < 64; c++) begin
            req(6'(c), 5'(c), 5'(c + 1), 5'(31 - c), 12'(c * 37 + 5));
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();

        for (int k = 0; k < 300; k++) begin
            req(ill[k % 6], 5'(k), 5'(k), 5'(k), 12'(k));
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();
        chk("count_saturated", 32'(illegal_count), 32'hFF);
        bus.out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            req(6'(i), 5'(i + 1), 5'(i + 1), 5'(i + 1), 12'h0);
            step();
        end
        bus.in_valid = 1'b0;
        chk("queued_level", 32'(fifo_level), 32'h3);
        #3 reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_level",     32'(fifo_level),    32'h0);
        chk("midrst_count",     32'(illegal_count), 32'h0);
        chk("midrst_out_instr", bus.out_instr,      32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        single("post_reset_add", 6'b000000, 5'd3, 5'd1, 5'd2, 12'h0, 32'h002081B3);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
